// File: rtl/weight_mem_writer.sv
// Weight-memory write path: packs narrow DRAM beats into full array words
// and drives the mem2 write port; flags weight_ready_o once a round is in.
module weight_mem_writer #(
    parameter int N_ROWS_ARRAY = 16,
    parameter int F_WIDTH      = 8,
    parameter int BEAT_LANES   = 4,
    parameter int ADDR_WIDTH   = 16
) (
    input  logic                             clk_i,
    input  logic                             rd_weight_rst,
    input  logic                             start_i,
    input  logic [ADDR_WIDTH-1:0]            base_addr_i,
    input  logic [ADDR_WIDTH-1:0]            num_words_i,
    input  logic [BEAT_LANES*F_WIDTH-1:0]    s_data_i,
    input  logic                             s_valid_i,
    output logic                             s_ready_o,
    output logic [N_ROWS_ARRAY*F_WIDTH-1:0]  mem2_data_o,
    output logic [ADDR_WIDTH-1:0]            wr_addrs_mem2_o,
    output logic                             wr_mem2_ld_o,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             weight_ready_o
);

    localparam int BPW = N_ROWS_ARRAY / BEAT_LANES;
    localparam int BW  = BEAT_LANES * F_WIDTH;
    localparam int WW  = N_ROWS_ARRAY * F_WIDTH;
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BPW - 1);

    typedef enum logic [1:0] {IDLE, PACK, FLUSH, DONE} state_e;

    state_e                state_q;
    logic [WW-1:0]         pack_q;
    logic [WW-1:0]         word_d;
    logic [CW-1:0]         beat_cnt_q;
    logic [ADDR_WIDTH-1:0] word_cnt_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] num_q;
    logic [WW-1:0]         data_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  ld_q;
    logic                  wready_q;

    // Current beat merged into the partial word at its lane slot
    always_comb begin
        word_d = pack_q;
        word_d[int'(beat_cnt_q)*BW +: BW] = s_data_i;
    end

    always_ff @(posedge clk_i or posedge rd_weight_rst) begin
        if (rd_weight_rst) begin
            state_q    <= IDLE;
            pack_q     <= '0;
            beat_cnt_q <= '0;
            word_cnt_q <= '0;
            base_q     <= '0;
            num_q      <= '0;
            data_q     <= '0;
            addr_q     <= '0;
            ld_q       <= 1'b0;
            wready_q   <= 1'b0;
        end else begin
            ld_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        base_q     <= base_addr_i;
                        num_q      <= num_words_i;
                        pack_q     <= '0;
                        beat_cnt_q <= '0;
                        word_cnt_q <= '0;
                        wready_q   <= (num_words_i == '0);
                        state_q    <= (num_words_i == '0) ? DONE : PACK;
                    end
                end
                PACK: begin
                    if (s_valid_i) begin
                        if (beat_cnt_q == LAST_BEAT) begin
                            beat_cnt_q <= '0;
                            data_q     <= word_d;
                            addr_q     <= base_q + word_cnt_q;
                            ld_q       <= 1'b1;
                            word_cnt_q <= word_cnt_q + ADDR_WIDTH'(1);
                            if (word_cnt_q == num_q - ADDR_WIDTH'(1)) begin
                                state_q <= FLUSH;
                            end
                        end else begin
                            pack_q     <= word_d;
                            beat_cnt_q <= beat_cnt_q + CW'(1);
                        end
                    end
                end
                FLUSH: begin
                    wready_q <= 1'b1;
                    state_q  <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_ready_o       = (state_q == PACK);
    assign busy_o          = (state_q != IDLE);
    assign done_o          = (state_q == DONE);
    assign mem2_data_o     = data_q;
    assign wr_addrs_mem2_o = addr_q;
    assign wr_mem2_ld_o    = ld_q;
    assign weight_ready_o  = wready_q;

endmodule

// File: tb/tb_weight_mem_writer.sv
// Bench for weight_mem_writer: beat-level reference model checked every
// cycle, plus hand-computed literal expectations per scenario.
module tb_weight_mem_writer;

    localparam int BPW = 4;
    localparam int BW  = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [15:0]  base = '0;
    logic [15:0]  num = '0;
    logic [31:0]  sdata = '0;
    logic         svalid = 1'b0;

    logic         s_ready_o;
    logic [127:0] mem2_data_o;
    logic [15:0]  wr_addrs_mem2_o;
    logic         wr_mem2_ld_o;
    logic         busy_o;
    logic         done_o;
    logic         weight_ready_o;

    weight_mem_writer #(
        .N_ROWS_ARRAY(16),
        .F_WIDTH(8),
        .BEAT_LANES(4),
        .ADDR_WIDTH(16)
    ) dut (
        .clk_i(clk),
        .rd_weight_rst(rst),
        .start_i(start),
        .base_addr_i(base),
        .num_words_i(num),
        .s_data_i(sdata),
        .s_valid_i(svalid),
        .s_ready_o(s_ready_o),
        .mem2_data_o(mem2_data_o),
        .wr_addrs_mem2_o(wr_addrs_mem2_o),
        .wr_mem2_ld_o(wr_mem2_ld_o),
        .busy_o(busy_o),
        .done_o(done_o),
        .weight_ready_o(weight_ready_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errs = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 streaming, 2 flush, 3 done
    int           cyc = 0;
    int           m_phase = 0;
    logic [15:0]  m_base = '0;
    logic [15:0]  m_n = '0;
    int           m_beats = 0;
    logic [31:0]  m_buf [BPW];
    logic         m_ld = 1'b0;
    logic         m_wr = 1'b0;
    logic [127:0] m_data = '0;
    logic [15:0]  m_addr = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0;
            m_beats = 0;
            m_ld = 1'b0;
            m_wr = 1'b0;
            m_data = '0;
            m_addr = '0;
        end else begin
            cyc++;
            m_ld = 1'b0;
            case (m_phase)
                0: if (start) begin
                    m_base = base;
                    m_n = num;
                    m_beats = 0;
                    m_wr = 1'b0;
                    if (num == 16'd0) begin
                        m_phase = 3;
                        m_wr = 1'b1;
                    end else begin
                        m_phase = 1;
                    end
                end
                1: if (svalid) begin
                    m_buf[m_beats % BPW] = sdata;
                    m_beats++;
                    if (m_beats % BPW == 0) begin
                        m_ld = 1'b1;
                        m_data = '0;
                        for (int i = 0; i < BPW; i++)
                            m_data[i*BW +: BW] = m_buf[i];
                        m_addr = m_base + 16'(m_beats / BPW - 1);
                        if (m_beats / BPW == int'(m_n)) m_phase = 2;
                    end
                end
                2: begin
                    m_phase = 3;
                    m_wr = 1'b1;
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Scoreboard of observed strobes and done pulses (cycle = edge + 1)
    logic [15:0]  sb_addr [$];
    logic [127:0] sb_data [$];
    int           sb_cyc [$];
    int           n_done = 0;
    int           done_cyc = 0;

    always @(negedge clk) begin
        chk("s_ready", s_ready_o, m_phase == 1);
        chk("busy", busy_o, m_phase != 0);
        chk("done", done_o, m_phase == 3);
        chk("wr_ld", wr_mem2_ld_o, m_ld);
        chk("data", mem2_data_o, m_data);
        chk("addr", wr_addrs_mem2_o, m_addr);
        if (m_phase != 3) chk("wready", weight_ready_o, m_wr);
        if (wr_mem2_ld_o) begin
            sb_addr.push_back(wr_addrs_mem2_o);
            sb_data.push_back(mem2_data_o);
            sb_cyc.push_back(cyc + 1);
        end
        if (done_o) begin
            n_done++;
            done_cyc = cyc + 1;
        end
    end

    int s_cyc = 0;
    int stalls = 0;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start(input logic [15:0] b, input logic [15:0] n);
        start = 1'b1;
        base = b;
        num = n;
        tick();
        s_cyc = cyc;
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d);
        bit ok;
        int k;
        ok = 1'b0;
        k = 0;
        svalid = 1'b1;
        sdata = d;
        while (!ok && k < 50) begin
            @(negedge clk);
            ok = s_ready_o;
            if (!ok) stalls++;
            tick();
            k++;
        end
        if (!ok) begin
            checks++;
            errs++;
            $display("FAIL beat_timeout: got no ready expected ready");
        end
    endtask

    function automatic logic [31:0] beat(input int b0);
        return {8'(b0 + 3), 8'(b0 + 2), 8'(b0 + 1), 8'(b0)};
    endfunction

    task automatic wait_done(input int d0);
        int k;
        k = 0;
        while (n_done == d0 && k < 40) begin
            tick();
            k++;
        end
        chk("done_seen", n_done > d0, 1);
    endtask

    int n0;
    int d0;

    initial begin
        repeat (3) tick();
        chk("rst_ld", wr_mem2_ld_o, 0);
        chk("rst_ready", s_ready_o, 0);
        chk("rst_wready", weight_ready_o, 0);
        rst = 1'b0;
        tick();

        // Basic word
        n0 = sb_addr.size();
        d0 = n_done;
        do_start(16'h0010, 16'd1);
        for (int i = 0; i < 4; i++) send_beat(beat(4 * i));
        svalid = 1'b0;
        wait_done(d0);
        repeat (2) tick();
        chk("basic_cnt", sb_addr.size() - n0, 1);
        chk("basic_addr", sb_addr[n0], 16'h0010);
        chk("basic_data", sb_data[n0],
            128'h0F0E0D0C0B0A09080706050403020100);
        chk("basic_ld_lat", sb_cyc[n0] - s_cyc, 5);
        chk("basic_done_lat", done_cyc - s_cyc, 6);
        chk("basic_wready", weight_ready_o, 1);

        // Back-to-back streaming
        n0 = sb_addr.size();
        d0 = n_done;
        stalls = 0;
        do_start(16'h0100, 16'd3);
        for (int i = 0; i < 12; i++) send_beat(beat(16 * i));
        svalid = 1'b0;
        chk("b2b_stalls", stalls, 0);
        wait_done(d0);
        tick();
        chk("b2b_cnt", sb_addr.size() - n0, 3);
        for (int i = 0; i < 3; i++) begin
            chk("b2b_cyc", sb_cyc[n0 + i] - s_cyc, 5 + 4 * i);
            chk("b2b_addr", sb_addr[n0 + i], 16'h0100 + 16'(i));
        end

        // Gapped valid plus address wrap
        n0 = sb_addr.size();
        d0 = n_done;
        do_start(16'hFFFF, 16'd2);
        for (int i = 0; i < 8; i++) begin
            send_beat(beat(16 + 4 * i));
            svalid = 1'b0;
            tick();
        end
        wait_done(d0);
        repeat (3) tick();
        chk("wrap_cnt", sb_addr.size() - n0, 2);
        chk("wrap_addr0", sb_addr[n0], 16'hFFFF);
        chk("wrap_addr1", sb_addr[n0 + 1], 16'h0000);
        chk("wrap_data0", sb_data[n0],
            128'h1F1E1D1C1B1A19181716151413121110);
        chk("wrap_data1", sb_data[n0 + 1],
            128'h2F2E2D2C2B2A29282726252423222120);
        chk("wrap_done_once", n_done - d0, 1);

        // Zero-length transfer
        n0 = sb_addr.size();
        d0 = n_done;
        do_start(16'h0500, 16'd0);
        wait_done(d0);
        repeat (3) tick();
        chk("zero_done_lat", done_cyc - s_cyc, 1);
        chk("zero_no_ld", sb_addr.size() - n0, 0);

        // Start pulsed during PACK is ignored
        n0 = sb_addr.size();
        d0 = n_done;
        do_start(16'h0200, 16'd2);
        for (int i = 0; i < 8; i++) begin
            send_beat(beat(64 + 4 * i));
            if (i == 1) begin
                svalid = 1'b0;
                start = 1'b1;
                base = 16'h0300;
                num = 16'd5;
                tick();
                start = 1'b0;
            end
        end
        svalid = 1'b0;
        wait_done(d0);
        repeat (4) tick();
        chk("ign_cnt", sb_addr.size() - n0, 2);
        chk("ign_addr0", sb_addr[n0], 16'h0200);
        chk("ign_addr1", sb_addr[n0 + 1], 16'h0201);
        chk("ign_idle", busy_o, 0);

        // Reset mid-word
        do_start(16'h0040, 16'd1);
        send_beat(32'hAAAAAAAA);
        send_beat(32'hBBBBBBBB);
        svalid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_ld", wr_mem2_ld_o, 0);
        chk("mid_rst_ready", s_ready_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_data", mem2_data_o, 0);
        chk("mid_rst_addr", wr_addrs_mem2_o, 0);
        chk("mid_rst_wready", weight_ready_o, 0);
        tick();
        rst = 1'b0;
        tick();
        n0 = sb_addr.size();
        d0 = n_done;
        do_start(16'h0041, 16'd1);
        for (int i = 0; i < 4; i++) send_beat(beat(80 + 4 * i));
        svalid = 1'b0;
        wait_done(d0);
        tick();
        chk("rst_new_cnt", sb_addr.size() - n0, 1);
        chk("rst_new_addr", sb_addr[n0], 16'h0041);
        chk("rst_new_data", sb_data[n0],
            128'h5F5E5D5C5B5A59585756555453525150);

        // Idle data rejection
        n0 = sb_addr.size();
        svalid = 1'b1;
        sdata = 32'hDEADBEEF;
        repeat (10) tick();
        svalid = 1'b0;
        chk("idle_no_ld", sb_addr.size() - n0, 0);
        d0 = n_done;
        do_start(16'h0700, 16'd1);
        for (int i = 0; i < 4; i++) send_beat(beat(96 + 4 * i));
        svalid = 1'b0;
        wait_done(d0);
        repeat (2) tick();
        chk("idle_after_addr", sb_addr[n0], 16'h0700);
        chk("idle_after_data", sb_data[n0],
            128'h6F6E6D6C6B6A69686766656463626160);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
